// File: rtl/mem_load_unit.sv
// RV32I load initiator: issues one read strobe per request, waits a fixed memory
// latency, then returns the lane-extracted, sign/zero-extended result as a pulse.
module mem_load_unit #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic [2:0]  i_req_funct3,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_misaligned,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_rstrb,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_lane;
    logic [2:0]  r_funct3;
    logic [3:0]  r_count;
    logic        r_mem_rstrb;
    logic [31:0] r_mem_addr;
    logic [31:0] r_rsp_data;
    logic        r_rsp_misaligned;

    logic        w_accept;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_reject;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_result;

    assign o_req_ready      = (r_state == IDLE) & ~i_reset;
    assign o_rsp_valid      = (r_state == RESP);
    assign o_mem_rstrb      = r_mem_rstrb;
    assign o_mem_addr       = r_mem_addr;
    assign o_rsp_data       = r_rsp_data;
    assign o_rsp_misaligned = r_rsp_misaligned;

    assign w_accept  = i_req_valid & o_req_ready;
    assign w_illegal = (i_req_funct3 == 3'd3) | (i_req_funct3 == 3'd6) | (i_req_funct3 == 3'd7);

    // Alignment is judged on the incoming request so a rejection never touches memory.
    always_comb begin
        w_misaligned = 1'b0;
        if (CHECK_ALIGN) begin
            if ((i_req_funct3 == 3'd1) || (i_req_funct3 == 3'd5)) begin
                w_misaligned = i_req_addr[0];
            end else if (i_req_funct3 == 3'd2) begin
                w_misaligned = (i_req_addr[1:0] != 2'b00);
            end
        end
    end

    assign w_reject = w_illegal | w_misaligned;

    always_comb begin
        w_byte = i_mem_rdata[7:0];
        case (r_lane)
            2'd0:    w_byte = i_mem_rdata[7:0];
            2'd1:    w_byte = i_mem_rdata[15:8];
            2'd2:    w_byte = i_mem_rdata[23:16];
            default: w_byte = i_mem_rdata[31:24];
        endcase
        w_half = r_lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (r_funct3)
            3'd0:    w_result = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_result = {{16{w_half[15]}}, w_half};
            3'd4:    w_result = {24'h000000, w_byte};
            3'd5:    w_result = {16'h0000, w_half};
            default: w_result = i_mem_rdata;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = w_reject ? RESP : READ;
                end
            end
            READ:    w_next_state = WAIT;
            WAIT: begin
                if (r_count == 4'd0) begin
                    w_next_state = RESP;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Rejected requests go straight to RESP with their error result registered at accept.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_lane           <= 2'b00;
            r_funct3         <= 3'b000;
            r_count          <= 4'd0;
            r_mem_rstrb      <= 1'b0;
            r_mem_addr       <= 32'h0000_0000;
            r_rsp_data       <= 32'h0000_0000;
            r_rsp_misaligned <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_lane   <= i_req_addr[1:0];
                        r_funct3 <= i_req_funct3;
                        if (w_reject) begin
                            r_rsp_data       <= 32'h0000_0000;
                            r_rsp_misaligned <= 1'b1;
                        end else begin
                            r_mem_rstrb <= 1'b1;
                            r_mem_addr  <= i_req_addr;
                        end
                    end
                end
                READ: begin
                    r_mem_rstrb <= 1'b0;
                    r_count     <= 4'(MEM_LATENCY - 1);
                end
                WAIT: begin
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end else begin
                        r_rsp_data       <= w_result;
                        r_rsp_misaligned <= 1'b0;
                    end
                end
                default: begin
                    r_mem_rstrb <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_load_unit.md
Name: mem_load_unit

Overview:
Read-side initiator for the single-cycle-strobe instruction/data memory port (mem_addr / mem_rstrb / mem_rdata). It accepts one RV32I load request at a time from the core (LB/LH/LW/LBU/LHU), issues a one-cycle read strobe, and waits a fixed read latency. It then extracts the addressed byte lane(s), applies sign- or zero-extension, and returns a one-cycle response pulse. It sits between the core's execute stage and the memory block.

Parameters:
MEM_LATENCY, 1, number of clock edges after the strobe-sampling edge before mem_rdata is valid; legal range 1..15.
CHECK_ALIGN, 1, 1 = misaligned LH/LHU/LW is rejected with an error; 0 = low address bits are ignored for halfword/word access and the read proceeds.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  load request present
req_ready  out  1  unit can accept a request this cycle
req_addr  in  32  byte address of the load
req_funct3  in  3  RV32I load funct3: 0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU
rsp_valid  out  1  one-cycle pulse; rsp_data/rsp_misaligned valid
rsp_data  out  32  extended load result
rsp_misaligned  out  1  request was rejected: misaligned or illegal funct3
mem_addr  out  32  byte address to memory; memory uses bits [31:2]
mem_rstrb  out  1  read strobe, sampled by memory on rising clk
mem_rdata  in  32  memory read word

Behaviour:
- Reset: asynchronous, active-high. While asserted: state=IDLE, mem_rstrb=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_misaligned=0, latched request cleared, latency counter=0.
- req_ready = (state==IDLE) & ~reset. It is a combinational decode and is the only path into the block.
- States: IDLE, READ, WAIT, RESP.
- IDLE:
  - On req_valid & req_ready, latch addr and funct3, then evaluate.
  - Illegal funct3 (3, 6, 7) -> RESP with error.
  - CHECK_ALIGN=1 and LH/LHU with addr[0]=1 -> RESP with error.
  - CHECK_ALIGN=1 and LW with addr[1:0]!=0 -> RESP with error.
  - Otherwise -> READ.
- READ: exactly one cycle. mem_rstrb=1 and mem_addr=latched addr, both registered outputs. Next state is WAIT, with the counter loaded to MEM_LATENCY-1.
- WAIT: mem_rstrb=0 and mem_addr holds.
  - While counter!=0: decrement.
  - When counter==0: on this edge, register the extracted result into rsp_data, set rsp_misaligned=0, go to RESP.
- RESP: rsp_valid=1 for exactly this cycle, then IDLE. There is no backpressure; the consumer must take the response in that cycle.
- Error path: rsp_data=0, rsp_misaligned=1, and mem_rstrb never asserts for the rejected request.
- rsp_data and rsp_misaligned hold their values after RESP until the next response is registered. rsp_valid is 0 outside RESP.
- Latency:
  - Normal load: accept edge at cycle 0, READ in cycle 1, WAIT in cycles 2..1+MEM_LATENCY, rsp_valid in cycle 2+MEM_LATENCY.
  - Error: rsp_valid in cycle 1.
- Throughput: a new request is accepted the cycle after RESP. Maximum rate is one load per 3+MEM_LATENCY cycles.
- Extraction (lane = addr[1:0]):
  - LB/LBU: byte mem_rdata[8*lane+7 : 8*lane].
  - LH/LHU: halfword at addr[1] (bits [15:0] or [31:16]).
  - LW: full word.
  - Signed variants replicate the MSB of the selected field into the upper bits; unsigned variants zero-fill.
  - CHECK_ALIGN=0: a halfword uses addr[1] only and a word ignores addr[1:0].
- mem_rdata is sampled only in the final WAIT cycle. Stale mem_rdata at other times is ignored.
- Reset mid-operation (READ/WAIT/RESP): abort immediately, with no rsp_valid for the aborted request. A read already issued to memory is abandoned and its data is never used.
- req_valid while not IDLE is ignored. The requester must hold req_valid until it sees req_ready.

Test Plan:
- Memory preloaded with byte 0x190=0x04030201, 0x194=0x08070605, 0x19C=0xFF0F0E0D. LB at 0x19F -> rsp_data=0xFFFFFFFF. LBU at 0x19F -> 0x000000FF. LB at 0x191 -> 0x00000002.
- LH at 0x19E -> 0xFFFFFF0F. LHU at 0x19E -> 0x0000FF0F. LH at 0x190 -> 0x00000201.
- LW at 0x194 with MEM_LATENCY=1 -> rsp_valid exactly 3 cycles after the accept edge, rsp_data=0x08070605, mem_rstrb high for exactly 1 cycle with mem_addr=0x194. Rerun with MEM_LATENCY=3 -> rsp_valid 5 cycles after accept.
- LW at 0x192, and separately funct3=3 at 0x190 (CHECK_ALIGN=1) -> rsp_valid 1 cycle after accept, rsp_misaligned=1, rsp_data=0, mem_rstrb never asserted. With CHECK_ALIGN=0, LW at 0x192 -> 0x04030201, rsp_misaligned=0.
- req_valid held high with back-to-back requests -> req_ready low during READ/WAIT/RESP, second request accepted the cycle after RESP, and each request produces exactly one rsp_valid.
- Reset asserted during WAIT -> all outputs go to 0 immediately with no rsp_valid. After release, req_ready=1 and a new LBU at 0x190 returns 0x00000001.
